// File: rtl/boron_key_sched.sv
// BORON key schedule: loads a master key and streams NUM_RK round keys over valid/ready.
// Optional round-key buffer with a registered read port is enabled by defining BORON_KEY_RKBUF_EN.
module boron_key_sched #(
    parameter int KEY_W  = 128,
    parameter int ROT    = 13,
    parameter int SBOX_N = 2,
    parameter int NUM_RK = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [63:0]      rk_data,
    output logic [4:0]       rk_idx,
    output logic             done,
    input  logic [4:0]       rd_idx,
    output logic [63:0]      rd_rk,
    output logic             rd_hit
);

    if (!(KEY_W == 80 || KEY_W == 128)) begin : g_bad_key_w
        $error("boron_key_sched: KEY_W must be 80 or 128");
    end
    if (ROT <= 0 || ROT >= KEY_W) begin : g_bad_rot
        $error("boron_key_sched: ROT must satisfy 0 < ROT < KEY_W");
    end
    if (SBOX_N < 1 || SBOX_N > 4) begin : g_bad_sbox_n
        $error("boron_key_sched: SBOX_N must be 1..4");
    end
    if (NUM_RK < 2 || NUM_RK > 32) begin : g_bad_num_rk
        $error("boron_key_sched: NUM_RK must be 2..32");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [4:0] LAST_IDX = 5'(NUM_RK - 1);

    state_t           state;
    logic [KEY_W-1:0] key_reg;
    logic [4:0]       idx;

    function automatic logic [3:0] boron_sbox(input logic [3:0] x);
        case (x)
            4'h0: boron_sbox = 4'hE;
            4'h1: boron_sbox = 4'h4;
            4'h2: boron_sbox = 4'hB;
            4'h3: boron_sbox = 4'h1;
            4'h4: boron_sbox = 4'h7;
            4'h5: boron_sbox = 4'h9;
            4'h6: boron_sbox = 4'hC;
            4'h7: boron_sbox = 4'hA;
            4'h8: boron_sbox = 4'hD;
            4'h9: boron_sbox = 4'h2;
            4'hA: boron_sbox = 4'h0;
            4'hB: boron_sbox = 4'hF;
            4'hC: boron_sbox = 4'h8;
            4'hD: boron_sbox = 4'h5;
            4'hE: boron_sbox = 4'h3;
            default: boron_sbox = 4'h6;
        endcase
    endfunction

    function automatic logic [KEY_W-1:0] key_update(input logic [KEY_W-1:0] k,
                                                    input logic [4:0] i);
        logic [KEY_W-1:0] s;
        s = (k << ROT) | (k >> (KEY_W - ROT));
        for (int j = 0; j < SBOX_N; j++) begin
            s[4*j +: 4] = boron_sbox(s[4*j +: 4]);
        end
        s[63:59] = s[63:59] ^ i;
        return s;
    endfunction

    assign busy     = (state == RUN);
    assign rk_valid = (state == RUN);
    assign done     = (state == DONE);
    assign rk_data  = (state == RUN) ? key_reg[63:0] : 64'h0;
    assign rk_idx   = idx;

    // The final handshake parks in DONE with key and index frozen; start is ignored while RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            key_reg <= '0;
            idx     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        key_reg <= key_in;
                        idx     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (rk_ready) begin
                        if (idx == LAST_IDX) begin
                            state <= DONE;
                        end else begin
                            key_reg <= key_update(key_reg, idx);
                            idx     <= idx + 5'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BORON_KEY_RKBUF_EN
    logic              handshake;
    logic              start_accept;
    logic [63:0]       rk_buf [NUM_RK];
    logic [NUM_RK-1:0] buf_valid;

    assign handshake    = (state == RUN) && rk_ready;
    assign start_accept = (state != RUN) && start;

    // Read port runs every cycle regardless of FSM state so keys can be fetched in any order.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_RK; i++) begin
                rk_buf[i] <= '0;
            end
            buf_valid <= '0;
            rd_rk     <= '0;
            rd_hit    <= 1'b0;
        end else begin
            if (start_accept) begin
                buf_valid <= '0;
            end else if (handshake) begin
                buf_valid[idx] <= 1'b1;
                rk_buf[idx]    <= key_reg[63:0];
            end
            if (int'(rd_idx) < NUM_RK) begin
                rd_rk  <= rk_buf[rd_idx];
                rd_hit <= buf_valid[rd_idx];
            end else begin
                rd_rk  <= '0;
                rd_hit <= 1'b0;
            end
        end
    end
`else
    logic unused_rd_idx;
    assign unused_rd_idx = ^rd_idx;
    assign rd_rk         = '0;
    assign rd_hit        = 1'b0;
`endif

endmodule

// File: tb/tb_boron_key_sched.sv
// Directed bench for boron_key_sched: 128-bit default instance plus an 80-bit, 4-key instance.
// Buffer checks follow whether BORON_KEY_RKBUF_EN is defined for the build.
module tb_boron_key_sched;

    localparam logic [3:0] SBOX_TAB [16] = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                                             4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};

    logic         clk = 1'b0;
    logic         reset, start, rk_ready;
    logic [127:0] key_in;
    logic         busy, rk_valid, done, rd_hit;
    logic [63:0]  rk_data, rd_rk;
    logic [4:0]   rk_idx, rd_idx;

    logic         start80, ready80;
    logic [79:0]  key80;
    logic         busy80, valid80, done80, hit80;
    logic [63:0]  data80, rd80;
    logic [4:0]   idx80;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_rk [26];
    logic [63:0] exp80 [4];

    always #5 clk = ~clk;

    boron_key_sched dut (
        .clk(clk), .reset(reset), .start(start), .key_in(key_in),
        .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
        .rk_idx(rk_idx), .done(done), .rd_idx(rd_idx), .rd_rk(rd_rk), .rd_hit(rd_hit)
    );

    boron_key_sched #(.KEY_W(80), .ROT(13), .SBOX_N(1), .NUM_RK(4)) dut80 (
        .clk(clk), .reset(reset), .start(start80), .key_in(key80),
        .busy(busy80), .rk_valid(valid80), .rk_ready(ready80), .rk_data(data80),
        .rk_idx(idx80), .done(done80), .rd_idx(5'd0), .rd_rk(rd80), .rd_hit(hit80)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("[TB] FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic r);
        start    = s;
        rk_ready = r;
    endtask

    // Independent reference of the 128-bit schedule used for the streamed sequence checks.
    task automatic buildModel();
        logic [127:0] k;
        k = '0;
        for (int i = 0; i < 26; i++) begin
            exp_rk[i] = k[63:0];
            k = {k[114:0], k[127:115]};
            for (int j = 0; j < 2; j++) begin
                k[4*j +: 4] = SBOX_TAB[k[4*j +: 4]];
            end
            k[63:59] = k[63:59] ^ 5'(i);
        end
    endtask

    initial begin
        int count;
        int cyc;
        reset = 1'b1;
        key_in = '0;
        rd_idx = 5'd0;
        start80 = 1'b0;
        ready80 = 1'b0;
        key80 = '0;
        applyStimulus(1'b0, 1'b0);
        buildModel();
        exp80[0] = 64'h0;
        exp80[1] = 64'h000000000000000E;
        exp80[2] = 64'h080000000001C00E;
        exp80[3] = 64'h100000003801C00E;
        tick();
        tick();
        reset = 1'b0;

        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_valid", 64'(rk_valid), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_idx", 64'(rk_idx), 64'd0);
        checkOutput("rst_data", rk_data, 64'h0);
        checkOutput("rst_rd_rk", rd_rk, 64'h0);
        checkOutput("rst_rd_hit", 64'(rd_hit), 64'd0);

        $display("[TB] full run, rk_ready tied high");
        applyStimulus(1'b1, 1'b1);
        tick();
        start = 1'b0;
        for (int i = 0; i < 26; i++) begin
            checkOutput("t1_valid", 64'(rk_valid), 64'd1);
            checkOutput("t1_busy", 64'(busy), 64'd1);
            checkOutput("t1_idx", 64'(rk_idx), 64'(i));
            checkOutput("t1_data", rk_data, exp_rk[i]);
            if (i == 0) checkOutput("t1_rk0", rk_data, 64'h0);
            if (i == 1) checkOutput("t1_rk1", rk_data, 64'h00000000000000EE);
            if (i == 2) checkOutput("t1_rk2", rk_data, 64'h08000000001DC0EE);
            tick();
        end
        checkOutput("t1_done", 64'(done), 64'd1);
        checkOutput("t1_valid_end", 64'(rk_valid), 64'd0);
        checkOutput("t1_busy_end", 64'(busy), 64'd0);

`ifdef BORON_KEY_RKBUF_EN
        $display("[TB] buffer read back in reverse");
        for (int r = 25; r >= 0; r--) begin
            rd_idx = 5'(r);
            tick();
            checkOutput("buf_rk", rd_rk, exp_rk[r]);
            checkOutput("buf_hit", 64'(rd_hit), 64'd1);
        end
        rd_idx = 5'd30;
        tick();
        checkOutput("buf_oob_rk", rd_rk, 64'h0);
        checkOutput("buf_oob_hit", 64'(rd_hit), 64'd0);
        rd_idx = 5'd0;
`else
        rd_idx = 5'd3;
        tick();
        checkOutput("nobuf_rk", rd_rk, 64'h0);
        checkOutput("nobuf_hit", 64'(rd_hit), 64'd0);
        rd_idx = 5'd0;
`endif

        $display("[TB] restart with rk_ready toggling");
        applyStimulus(1'b1, 1'b0);
        tick();
        start = 1'b0;
        checkOutput("t2_done_clear", 64'(done), 64'd0);
`ifdef BORON_KEY_RKBUF_EN
        tick();
        checkOutput("t2_buf_hit_clear", 64'(rd_hit), 64'd0);
`endif
        count = 0;
        cyc = 0;
        while (count < 26 && cyc < 200) begin
            rk_ready = (cyc % 3 == 0);
            checkOutput("t2_valid", 64'(rk_valid), 64'd1);
            checkOutput("t2_idx", 64'(rk_idx), 64'(count));
            checkOutput("t2_data", rk_data, exp_rk[count]);
            tick();
            if (rk_ready) count++;
            cyc++;
        end
        checkOutput("t2_beats", 64'(count), 64'd26);
        checkOutput("t2_done", 64'(done), 64'd1);

        $display("[TB] start pulses while busy");
        applyStimulus(1'b1, 1'b1);
        tick();
        start = 1'b0;
        for (int i = 0; i < 26; i++) begin
            start = (i == 10 || i == 25);
            checkOutput("t3_idx", 64'(rk_idx), 64'(i));
            checkOutput("t3_data", rk_data, exp_rk[i]);
            tick();
        end
        start = 1'b0;
        checkOutput("t3_done", 64'(done), 64'd1);
        checkOutput("t3_busy", 64'(busy), 64'd0);
        tick();
        checkOutput("t3_no_reload", 64'(done), 64'd1);

        $display("[TB] reset mid-schedule");
        applyStimulus(1'b1, 1'b1);
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        checkOutput("t4_idx7", 64'(rk_idx), 64'd7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("t4_valid", 64'(rk_valid), 64'd0);
        checkOutput("t4_idx", 64'(rk_idx), 64'd0);
        checkOutput("t4_busy", 64'(busy), 64'd0);
        tick();
        checkOutput("t4_idle_valid", 64'(rk_valid), 64'd0);
        applyStimulus(1'b1, 1'b1);
        tick();
        start = 1'b0;
        for (int i = 0; i < 26; i++) begin
            checkOutput("t4_replay", rk_data, exp_rk[i]);
            tick();
        end
        checkOutput("t4_done", 64'(done), 64'd1);

        $display("[TB] 80-bit, SBOX_N=1, NUM_RK=4");
        start80 = 1'b1;
        ready80 = 1'b1;
        tick();
        start80 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("k80_valid", 64'(valid80), 64'd1);
            checkOutput("k80_idx", 64'(idx80), 64'(i));
            checkOutput("k80_data", data80, exp80[i]);
            tick();
        end
        checkOutput("k80_done", 64'(done80), 64'd1);
        checkOutput("k80_valid_end", 64'(valid80), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
